inst_loader: RTL and testbench

- Writer side of the instruction memory, which the CPU only reads, combinationally, by PC.
- Receives a framed byte stream over a valid/ready handshake.
- Assembles the bytes into 16-bit instruction words and writes them sequentially into instruction memory.
- Verifies a checksum, then asserts the CPU enable so the S-Machine runs the loaded program. It gates the `enable` input of the SMachine top level.

---
 rtl/inst_loader.sv | 125 ++++++++++++
 tb/tb_inst_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction memory loader: receives a framed byte stream (LEN, N high/low
// byte pairs, XOR checksum), writes each assembled 16-bit word into the
// instruction memory and releases the CPU enable only after a verified load.
module inst_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  IDLE_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    remaining;
  logic [7:0]    checksum;
  logic [CW-1:0] idle_cnt;
  logic          xfer;
  logic          waiting;
  logic          idle_hit;

  assign xfer     = byte_valid & byte_ready;
  assign waiting  = (state == S_LEN) || (state == S_HI) ||
                    (state == S_LO)  || (state == S_CHK);
  assign idle_hit = waiting && !xfer && (idle_cnt == IDLE_MAX);

  // Next-state selection; an expired idle count overrides staying put.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (start) state_nxt = S_LEN;
      S_LEN:   if (xfer) state_nxt = (byte_in == 8'h00) ? S_ERR : S_HI;
      S_HI:    if (xfer) state_nxt = S_LO;
      S_LO:    if (xfer) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (remaining == 8'd1) ? S_CHK : S_HI;
      S_CHK:   if (xfer) state_nxt = (byte_in == checksum) ? S_RUN : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (idle_hit) state_nxt = S_ERR;
  end

  // State, registered outputs derived from the next state, and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 16'h0000;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      remaining  <= 8'h00;
      checksum   <= 8'h00;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt == S_LEN) || (state_nxt == S_HI) ||
                    (state_nxt == S_LO)  || (state_nxt == S_CHK);
      mem_we     <= (state_nxt == S_WRITE);
      busy       <= (state_nxt == S_LEN) || (state_nxt == S_HI) ||
                    (state_nxt == S_LO)  || (state_nxt == S_WRITE) ||
                    (state_nxt == S_CHK);
      cpu_enable <= (state_nxt == S_RUN);
      error      <= (state_nxt == S_ERR);

      if (xfer || (state_nxt != state)) begin
        idle_cnt <= '0;
      end else if (waiting) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            mem_addr  <= BASE_ADDR;
            checksum  <= 8'h00;
            remaining <= 8'h00;
          end
        end
        S_LEN: begin
          if (xfer) begin
            remaining <= byte_in;
            checksum  <= checksum ^ byte_in;
          end
        end
        S_HI: begin
          if (xfer) begin
            mem_wdata[15:8] <= byte_in;
            checksum        <= checksum ^ byte_in;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_wdata[7:0] <= byte_in;
            checksum       <= checksum ^ byte_in;
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + 8'd1;
          remaining <= remaining - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: one instance at BASE_ADDR 00 and one at FF
// share the same stimulus; both use a short idle timeout of 8 cycles.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready, mem_we, cpu_enable, busy, error;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        byte_ready_w, mem_we_w, cpu_enable_w, busy_w, error_w;
  logic [7:0]  mem_addr_w;
  logic [15:0] mem_wdata_w;

  int checks = 0;
  int errors = 0;

  logic [23:0] wlog[$];
  logic [23:0] wlog_w[$];

  inst_loader #(.BASE_ADDR(8'h00), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_enable(cpu_enable),
    .busy(busy), .error(error)
  );

  inst_loader #(.BASE_ADDR(8'hFF), .TIMEOUT(8)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready_w), .mem_we(mem_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .cpu_enable(cpu_enable_w),
    .busy(busy_w), .error(error_w)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Record every write strobe seen by each instance.
  always @(negedge clk) begin
    if (mem_we)   wlog.push_back({mem_addr, mem_wdata});
    if (mem_we_w) wlog_w.push_back({mem_addr_w, mem_wdata_w});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] logEntry(input int idx);
    if (wlog.size() > idx) return wlog[idx];
    return 24'hxxxxxx;
  endfunction

  function automatic logic [23:0] logEntryW(input int idx);
    if (wlog_w.size() > idx) return wlog_w[idx];
    return 24'hxxxxxx;
  endfunction

  // Present one byte after an optional idle gap and wait for its transfer.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit done;
    done = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
    end
    checkOutput("byte_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] chk, input int gap);
    applyStimulus(8'h02, gap);
    applyStimulus(8'h12, gap);
    applyStimulus(8'h34, gap);
    applyStimulus(8'hAB, gap);
    applyStimulus(8'hCD, gap);
    applyStimulus(chk, gap);
    byte_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("rst_mem_we",     {31'd0, mem_we},     32'd0);
    checkOutput("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
    checkOutput("rst_busy",       {31'd0, busy},       32'd0);
    checkOutput("rst_error",      {31'd0, error},      32'd0);
    checkOutput("rst_mem_addr",   {24'd0, mem_addr},   32'h00);
    checkOutput("rst_mem_addr_w", {24'd0, mem_addr_w}, 32'hFF);
    checkOutput("rst_mem_wdata",  {16'd0, mem_wdata},  32'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic load and address wrap");
    wlog.delete();
    wlog_w.delete();
    pulseStart();
    checkOutput("start_busy",       {31'd0, busy},       32'd1);
    checkOutput("start_byte_ready", {31'd0, byte_ready}, 32'd1);
    sendFrame(8'h42, 0);
    checkOutput("basic_cpu_enable", {31'd0, cpu_enable}, 32'd1);
    checkOutput("basic_busy",       {31'd0, busy},       32'd0);
    checkOutput("basic_error",      {31'd0, error},      32'd0);
    checkOutput("basic_writes",     wlog.size(),         32'd2);
    checkOutput("basic_w0",         {8'd0, logEntry(0)}, 32'h001234);
    checkOutput("basic_w1",         {8'd0, logEntry(1)}, 32'h01ABCD);
    checkOutput("wrap_writes",      wlog_w.size(),       32'd2);
    checkOutput("wrap_w0",          {8'd0, logEntryW(0)}, 32'hFF1234);
    checkOutput("wrap_w1",          {8'd0, logEntryW(1)}, 32'h00ABCD);
    checkOutput("wrap_cpu_enable",  {31'd0, cpu_enable_w}, 32'd1);

    $display("[TB] restart from RUN, then bad checksum");
    wlog.delete();
    @(negedge clk);
    checkOutput("run_byte_ready_pre", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1;
    pulseStart();
    checkOutput("restart_cpu_enable", {31'd0, cpu_enable}, 32'd0);
    checkOutput("restart_byte_ready", {31'd0, byte_ready}, 32'd1);
    sendFrame(8'h43, 0);
    checkOutput("bad_writes",     wlog.size(),            32'd2);
    checkOutput("bad_w1",         {8'd0, logEntry(1)},    32'h01ABCD);
    checkOutput("bad_error",      {31'd0, error},         32'd1);
    checkOutput("bad_cpu_enable", {31'd0, cpu_enable},    32'd0);
    checkOutput("bad_busy",       {31'd0, busy},          32'd0);

    $display("[TB] reload after error");
    pulseStart();
    checkOutput("reload_error_cleared", {31'd0, error}, 32'd0);
    sendFrame(8'h42, 0);
    checkOutput("reload_cpu_enable", {31'd0, cpu_enable}, 32'd1);
    checkOutput("reload_error",      {31'd0, error},      32'd0);

    $display("[TB] zero length");
    wlog.delete();
    pulseStart();
    applyStimulus(8'h00, 0);
    byte_valid = 1'b0;
    checkOutput("zero_error", {31'd0, error}, 32'd1);
    checkOutput("zero_busy",  {31'd0, busy},  32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_writes", wlog.size(), 32'd0);

    $display("[TB] throttled source");
    wlog.delete();
    pulseStart();
    sendFrame(8'h42, 3);
    checkOutput("throttle_cpu_enable", {31'd0, cpu_enable}, 32'd1);
    checkOutput("throttle_writes",     wlog.size(),         32'd2);

    $display("[TB] transfer on the last idle cycle beats the timeout");
    wlog.delete();
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    byte_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("edge_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h27, 0);
    byte_valid = 1'b0;
    checkOutput("edge_cpu_enable", {31'd0, cpu_enable}, 32'd1);
    checkOutput("edge_w0",         {8'd0, logEntry(0)}, 32'h001234);

    $display("[TB] stall after high byte times out");
    wlog.delete();
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    byte_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("stall7_error", {31'd0, error}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("stall8_error", {31'd0, error}, 32'd1);
    checkOutput("stall8_busy",  {31'd0, busy},  32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_writes", wlog.size(), 32'd0);

    $display("[TB] asynchronous reset mid-LO");
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("arst_busy",       {31'd0, busy},       32'd0);
    checkOutput("arst_mem_wdata",  {16'd0, mem_wdata},  32'h0000);
    checkOutput("arst_mem_addr_w", {24'd0, mem_addr_w}, 32'hFF);
    byte_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
